dp_share_arbiter: RTL and testbench
===================================

// Module: dp_share_arbiter
// PURPOSE
//  Shares one 2-stage pipelined AND/XOR datapath (32-bit operand pair in, (in1 & in2) ^ 1 out)
//  between two requesters, A and B. Round-robin grant, valid/ready on request and response side.
//  Drives the datapath's stage-2 enable (dp_control) and replays operands into the free-running stage 1.
//  Routes each result back to its issuer. Keeps per-requester issue counters.
// PARAMETERS
//  DATA_W  32  operand/result width
//  CNT_W   16  width of issue counters cnt_a/cnt_b
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       synchronous reset, active-high
//  a_valid      in   1       requester A operand pair valid
//  a_ready      out  1       A handshake accepted this cycle (fire = a_valid & a_ready)
//  a_in1/a_in2  in   DATA_W  A operands
//  a_rsp_valid  out  1       result for A valid
//  a_rsp_ready  in   1       A accepts result
//  b_*          --   --      same set as A, for requester B
//  rsp_data     out  DATA_W  result data, shared by A and B; = dp_out
//  dp_in1/2     out  DATA_W  operands to datapath stage 1 (captured every cycle, no enable)
//  dp_control   out  1       datapath stage-2 load enable
//  dp_out       in   DATA_W  datapath result (combinational from stage 2)
//  cnt_a/cnt_b  out  CNT_W   issues granted to A/B, wrap modulo 2^CNT_W
// BEHAVIOUR
//  Tracking state: s1_v/s1_tag (stage 1 holds valid entry, owner), s1 operand shadow,
//   s2_v/s2_tag (stage 2 holds valid entry, owner), rr_pri (0=A first, 1=B first).
//  Reset: s1_v=s2_v=0, rr_pri=0, cnt_a=cnt_b=0. Datapath stage 2 clears on the same rst.
//   All ready/rsp_valid/dp_control outputs are 0 while in reset.
//  Reset mid-operation: all in-flight entries are dropped; no response is issued for them.
//  rsp_fire = s2_v & (tag A ? a_rsp_ready : b_rsp_ready).
//  dp_control = s1_v & (!s2_v | rsp_fire).
//  hold = s1_v & !dp_control. When hold=1: a_ready=b_ready=0 and dp_in = s1 shadow (replay),
//   so stage 1 recaptures identical data.
//  When hold=0: grant goes to the valid requester; if both are valid, to rr_pri.
//   Ready is asserted to the winner only. dp_in = winner operands; dp_in = 0 if no winner.
//  On grant: s1_v<=1, s1_tag<=winner, shadow<=operands, rr_pri<=!winner, winner counter +1.
//  No grant and !hold: s1_v<=0. No grant: rr_pri is unchanged.
//  On dp_control: s2_v<=1, s2_tag<=s1_tag. Else if rsp_fire: s2_v<=0. Else s2 holds.
//  a_rsp_valid = s2_v & tag==A; b_rsp_valid = s2_v & tag==B.
//   rsp_data is stable while rsp_valid is held.
//  Latency: request fire in cycle T -> rsp_valid in T+2, when rsp_ready is high throughout.
//  Throughput: one issue per cycle at full back-pressure-free rate.
//  Ordering: strictly in issue order. Max 2 in flight (stage 1 + stage 2).
//  Response stall on stage 2 blocks both requesters, including the non-stalled owner.
//   This head-of-line blocking is intended.
//  Ready may depend combinationally on valid and rsp_ready. No combinational path from dp_out.
// TESTING
//  1 Single A: a_in1=0xFFFF0000, a_in2=0x0F0F0F0F, fire at T -> a_rsp_valid at T+2,
//     rsp_data=0x0F0F0001; b_rsp_valid stays 0.
//  2 A,B both valid 6 cycles, rsp_ready=1 -> grants A,B,A,B,A,B; responses in same order;
//     cnt_a=cnt_b=3.
//  3 A rsp_ready=0 with 2 entries in flight -> dp_control=0, a_ready=b_ready=0,
//     dp_in=shadow; data intact; release -> both results delivered in order.
//  4 rst asserted with 2 in flight -> next cycle all rsp_valid=0, counters 0;
//     subsequent request completes normally with latency 2.
//  5 CNT_W=4: 17 A grants -> cnt_a=1 (wrap); B only valid after A grant -> B granted next (rr).
//  6 a_valid toggles with no grant possible (hold) -> no counter change,
//     no lost/duplicated response.

Source files
------------

// File: rtl/dp_share_arbiter.sv
// Round-robin sharing of one 2-stage AND/XOR datapath between requesters A and B.
// Tracks stage occupancy/ownership, drives the stage-2 enable and routes results back.
module dp_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_in1,
    input  logic [DATA_W-1:0] a_in2,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_in1,
    input  logic [DATA_W-1:0] b_in2,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,

    output logic [DATA_W-1:0] rsp_data,

    output logic [DATA_W-1:0] dp_in1,
    output logic [DATA_W-1:0] dp_in2,
    output logic              dp_control,
    input  logic [DATA_W-1:0] dp_out,

    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both high.
    // Requesters hold operands while valid and not ready; the response side holds
    // rsp_valid and rsp_data stable until rsp_ready is seen.
    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    logic              s1_v;
    logic              s1_tag;
    logic [DATA_W-1:0] s1_op1;
    logic [DATA_W-1:0] s1_op2;
    logic              s2_v;
    logic              s2_tag;
    logic              rr_pri;

    logic              rsp_fire;
    logic              load_s2;
    logic              hold;
    logic              grant_a;
    logic              grant_b;

    always_comb begin
        rsp_fire = s2_v & ((s2_tag == TAG_A) ? a_rsp_ready : b_rsp_ready);
        load_s2  = s1_v & (~s2_v | rsp_fire);
        hold     = s1_v & ~load_s2;

        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!hold && !rst) begin
            if (a_valid && b_valid) begin
                grant_a = (rr_pri == TAG_A);
                grant_b = (rr_pri == TAG_B);
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    // Stage 1 of the datapath is free-running, so a held entry must be replayed
    // from the shadow to keep its contents intact.
    always_comb begin
        dp_in1 = '0;
        dp_in2 = '0;
        if (hold) begin
            dp_in1 = s1_op1;
            dp_in2 = s1_op2;
        end else if (grant_a) begin
            dp_in1 = a_in1;
            dp_in2 = a_in2;
        end else if (grant_b) begin
            dp_in1 = b_in1;
            dp_in2 = b_in2;
        end
    end

    assign a_ready     = grant_a;
    assign b_ready     = grant_b;
    assign dp_control  = load_s2 & ~rst;
    assign a_rsp_valid = s2_v & (s2_tag == TAG_A) & ~rst;
    assign b_rsp_valid = s2_v & (s2_tag == TAG_B) & ~rst;
    assign rsp_data    = dp_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_tag <= TAG_A;
            s1_op1 <= '0;
            s1_op2 <= '0;
            s2_v   <= 1'b0;
            s2_tag <= TAG_A;
            rr_pri <= TAG_A;
            cnt_a  <= '0;
            cnt_b  <= '0;
        end else begin
            if (grant_a || grant_b) begin
                s1_v   <= 1'b1;
                s1_tag <= grant_b ? TAG_B : TAG_A;
                s1_op1 <= dp_in1;
                s1_op2 <= dp_in2;
                rr_pri <= grant_b ? TAG_A : TAG_B;
                if (grant_a) cnt_a <= cnt_a + 1'b1;
                if (grant_b) cnt_b <= cnt_b + 1'b1;
            end else if (!hold) begin
                s1_v <= 1'b0;
            end

            if (load_s2) begin
                s2_v   <= 1'b1;
                s2_tag <= s1_tag;
            end else if (rsp_fire) begin
                s2_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Directed bench for dp_share_arbiter with a behavioural datapath and a response scoreboard.
module tb_dp_share_arbiter;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int W      = DATA_W + 1;

  logic              clk;
  logic              rst;
  logic              a_valid, a_ready, a_rsp_valid, a_rsp_ready;
  logic              b_valid, b_ready, b_rsp_valid, b_rsp_ready;
  logic [DATA_W-1:0] a_in1, a_in2, b_in1, b_in2;
  logic [DATA_W-1:0] rsp_data, dp_in1, dp_in2, dp_out;
  logic              dp_control;
  logic [CNT_W-1:0]  cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W-1:0] exp_q[$];

  // datapath model: stage 1 free-running, stage 2 loaded by dp_control
  logic [DATA_W-1:0] dp_s1_a, dp_s1_b, dp_s2;

  dp_share_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_in1(a_in1), .a_in2(a_in2),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
    .b_valid(b_valid), .b_ready(b_ready), .b_in1(b_in1), .b_in2(b_in2),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
    .rsp_data(rsp_data), .dp_in1(dp_in1), .dp_in2(dp_in2),
    .dp_control(dp_control), .dp_out(dp_out),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    dp_s1_a <= dp_in1;
    dp_s1_b <= dp_in2;
    if (rst) dp_s2 <= '0;
    else if (dp_control) dp_s2 <= (dp_s1_a & dp_s1_b) ^ 32'd1;
  end
  assign dp_out = dp_s2;

  task automatic check(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // scoreboard monitor: push on issue, pop and compare on response
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (a_rsp_valid && b_rsp_valid) check("rsp_valid_exclusive", 32'd1, 32'd0);
        if ((a_rsp_valid && a_rsp_ready) || (b_rsp_valid && b_rsp_ready)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_owner", {31'd0, b_rsp_valid}, {31'd0, e[DATA_W]});
            check("rsp_data", rsp_data, e[DATA_W-1:0]);
          end
        end
        if (a_valid && a_ready) exp_q.push_back({1'b0, (a_in1 & a_in2) ^ 32'd1});
        if (b_valid && b_ready) exp_q.push_back({1'b1, (b_in1 & b_in2) ^ 32'd1});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input logic is_b, output int t);
    t = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (is_b ? b_rsp_valid : a_rsp_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !a_rsp_valid && !b_rsp_valid) break;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    next_cycle();
  endtask

  initial begin
    int t0, t1;
    logic [DATA_W-1:0] x2_1, x2_2;
    rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    a_in1 = '0; a_in2 = '0; b_in1 = '0; b_in2 = '0;
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;

    // reset: outputs quiet even with requests pending
    next_cycle();
    @(negedge clk);
    check("reset_a_ready", {31'd0, a_ready}, 32'd0);
    check("reset_b_ready", {31'd0, b_ready}, 32'd0);
    check("reset_dp_control", {31'd0, dp_control}, 32'd0);
    next_cycle();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    check("reset_cnt_a", {28'd0, cnt_a}, 32'd0);
    check("reset_cnt_b", {28'd0, cnt_b}, 32'd0);
    check("reset_rsp_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);

    // 1: single A, latency 2
    next_cycle();
    a_valid = 1'b1; a_in1 = 32'hFFFF0000; a_in2 = 32'h0F0F0F0F;
    @(negedge clk);
    check("t1_a_ready", {31'd0, a_ready}, 32'd1);
    t0 = cyc;
    next_cycle();
    a_valid = 1'b0;
    wait_rsp(1'b0, t1);
    check("t1_latency", t1 - t0, 32'd2);
    check("t1_rsp_data", rsp_data, 32'h0F0F0001);
    check("t1_b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    drain();

    // 2: both valid for 6 cycles, alternating grants from A
    do_reset();
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1; b_valid = 1'b1;
      a_in1 = 32'hA5A5_0000 | i; a_in2 = 32'hFFFF_00F0 | (i << 8);
      b_in1 = 32'h5A5A_FF00 | i; b_in2 = 32'h0FF0_FFFF ^ (i << 4);
      @(negedge clk);
      check("t2_a_ready", {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("t2_b_ready", {31'd0, b_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      next_cycle();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    drain();
    check("t2_cnt_a", {28'd0, cnt_a}, 32'd3);
    check("t2_cnt_b", {28'd0, cnt_b}, 32'd3);

    // 3 + 6: stage-2 stall on A, requests toggling while held
    a_rsp_ready = 1'b0;
    a_valid = 1'b1; a_in1 = 32'h1234_5678; a_in2 = 32'hFF00_FF00;
    @(negedge clk);
    check("t3_grant1", {31'd0, a_ready}, 32'd1);
    next_cycle();
    x2_1 = 32'hCAFE_BABE; x2_2 = 32'h0F0F_F0F0;
    a_in1 = x2_1; a_in2 = x2_2;
    @(negedge clk);
    check("t3_grant2", {31'd0, a_ready}, 32'd1);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      a_valid = k[0]; b_valid = 1'b1;
      a_in1 = 32'hDEAD_0000 + k; a_in2 = 32'hFFFF_FFFF;
      b_in1 = 32'hBEEF_0000 + k; b_in2 = 32'hFFFF_FFFF;
      @(negedge clk);
      check("t3_hold_a_ready", {31'd0, a_ready}, 32'd0);
      check("t3_hold_b_ready", {31'd0, b_ready}, 32'd0);
      check("t3_hold_dp_control", {31'd0, dp_control}, 32'd0);
      check("t3_replay_in1", dp_in1, x2_1);
      check("t3_replay_in2", dp_in2, x2_2);
      check("t3_held_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
      check("t3_held_rsp_data", rsp_data, (32'h1234_5678 & 32'hFF00_FF00) ^ 32'd1);
      next_cycle();
    end
    check("t6_cnt_a", {28'd0, cnt_a}, 32'd5);
    check("t6_cnt_b", {28'd0, cnt_b}, 32'd3);
    a_valid = 1'b0; b_valid = 1'b0; a_rsp_ready = 1'b1;
    drain();

    // 4: reset with two entries in flight
    a_valid = 1'b1; a_in1 = 32'h1111_1111; a_in2 = 32'hFFFF_FFFF;
    next_cycle();
    a_valid = 1'b0; b_valid = 1'b1; b_in1 = 32'h2222_2222; b_in2 = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t4_b_ready", {31'd0, b_ready}, 32'd1);
    next_cycle();
    b_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t4_in_reset_rsp_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("t4_after_rsp_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
    check("t4_cnt_a", {28'd0, cnt_a}, 32'd0);
    check("t4_cnt_b", {28'd0, cnt_b}, 32'd0);
    next_cycle();
    b_valid = 1'b1; b_in1 = 32'h8765_4321; b_in2 = 32'hF0F0_F0F0;
    @(negedge clk);
    check("t4_new_b_ready", {31'd0, b_ready}, 32'd1);
    t0 = cyc;
    next_cycle();
    b_valid = 1'b0;
    wait_rsp(1'b1, t1);
    check("t4_latency", t1 - t0, 32'd2);
    check("t4_rsp_data", rsp_data, 32'h8060_4021);
    drain();

    // 5: 17 A grants wrap a 4-bit counter; then B wins the round robin
    for (int i = 0; i < 17; i++) begin
      a_valid = 1'b1; a_in1 = 32'h0101_0101 * (i + 1); a_in2 = 32'h7FFF_FFFE;
      @(negedge clk);
      check("t5_a_ready", {31'd0, a_ready}, 32'd1);
      next_cycle();
    end
    a_valid = 1'b1; b_valid = 1'b1; b_in1 = 32'h0000_FFFF; b_in2 = 32'h00FF_00FF;
    @(negedge clk);
    check("t5_cnt_a_wrap", {28'd0, cnt_a}, 32'd1);
    check("t5_rr_b_ready", {31'd0, b_ready}, 32'd1);
    check("t5_rr_a_ready", {31'd0, a_ready}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t5_rr_next_a", {31'd0, a_ready}, 32'd1);
    next_cycle();
    a_valid = 1'b0; b_valid = 1'b0;
    drain();
    check("t5_cnt_a", {28'd0, cnt_a}, 32'd2);
    check("t5_cnt_b", {28'd0, cnt_b}, 32'd2);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
